// File: rtl/pitch_pkg.sv
// pitch_pkg: frame geometry, sample types and reader FSM states shared by the
// pitch-shift frame buffer, its writer and its reader.
package pitch_pkg;
    localparam int FRAME_LEN = 2048;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int SAMPLE_W  = 32;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [IDX_W-1:0] bin_idx_t;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} rd_state_t;
    function automatic int rd_fifo_depth(input int rd_lat);
        return 1 << $clog2(rd_lat + 2);
    endfunction
endpackage

// File: rtl/ps_rd_fifo.sv
// ps_rd_fifo: small synchronous FIFO holding shifter read data plus its last tag.
module ps_rd_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_i);
            rd_q  <= rd_q + AW'(pop_i);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/pitch_shift_reader.sv
// pitch_shift_reader: sweeps the shifter memory for one frame and re-emits the bins
// as a valid/ready stream, absorbing the fixed read latency with a credit-bounded FIFO.
module pitch_shift_reader #(
    parameter int FRAME_LEN = pitch_pkg::FRAME_LEN,
    parameter int IDX_W     = pitch_pkg::IDX_W,
    parameter int DATA_W    = pitch_pkg::SAMPLE_W,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [IDX_W-1:0]  output_index,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              frame_done
);
    import pitch_pkg::*;
    localparam int DEPTH = rd_fifo_depth(RD_LAT);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    rd_state_t        state_q;
    logic [IDX_W-1:0] ptr_q, idx_q, iss_idx;
    // stage 0 is the cycle the address sits on output_index; stage RD_LAT sees its data
    logic [RD_LAT:0]  vld_q, lst_q;
    logic             done_q, issue, push, pop, empty;
    logic [CW-1:0]    count, inflight;
    logic [DATA_W:0]  head;
    assign iss_idx  = (state_q == S_IDLE) ? '0 : ptr_q;
    assign inflight = CW'($countones(vld_q));
    assign pop      = m_valid & m_ready;
    assign push     = vld_q[RD_LAT];
    assign issue    = (state_q == S_IDLE) ? start
                    : (state_q == S_READ) && (int'(count) + int'(inflight) - int'(pop) < DEPTH);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            vld_q  <= {vld_q[RD_LAT-1:0], issue};
            lst_q  <= {lst_q[RD_LAT-1:0], issue && iss_idx == LAST_IDX};
            done_q <= 1'b0;
            if (issue) begin
                idx_q <= iss_idx;
                ptr_q <= iss_idx + 1'b1;
            end
            case (state_q)
                S_IDLE:  if (start) state_q <= S_READ;
                S_READ:  if (issue && ptr_q == LAST_IDX) state_q <= S_DRAIN;
                S_DRAIN: if (pop && head[DATA_W]) begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    ps_rd_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .din_i  ({lst_q[RD_LAT], data_out}),
        .dout_o (head),
        .count_o(count),
        .empty_o(empty)
    );
    assign busy         = state_q != S_IDLE;
    assign output_index = idx_q;
    assign frame_done   = done_q;
    assign m_valid      = !empty;
    assign m_data       = m_valid ? head[DATA_W-1:0] : '0;
    assign m_last       = m_valid & head[DATA_W];
endmodule

// File: tb/tb_pitch_shift_reader.sv
// tb_pitch_shift_reader: randomized drain, backpressure, restart and reset scenarios for
// pitch_shift_reader at read latencies 1 and 3, scored against a frame-level model.
module tb_pitch_shift_reader;
    localparam int FL = 2048;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] start_v, busy_v, val_v, done_v;
    int mode [2];
    logic [31:0] seed [2];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int L = (g == 0) ? 1 : 3;
        logic busy, m_valid, m_last, frame_done, rdy, hold;
        logic [10:0] oidx;
        logic [31:0] dout, mdata;
        logic [31:0] dp [L];
        logic [32:0] prev;
        int beat;
        pitch_shift_reader #(.RD_LAT(L)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_v[g]),
            .busy        (busy),
            .output_index(oidx),
            .data_out    (dout),
            .m_data      (mdata),
            .m_valid     (m_valid),
            .m_ready     (rdy),
            .m_last      (m_last),
            .frame_done  (frame_done)
        );
        assign busy_v[g] = busy;
        assign val_v[g]  = m_valid;
        assign done_v[g] = frame_done;
        assign dout      = dp[L-1];
        // shifter memory: bin i holds (i<<16)^seed, returned L cycles after its address
        always @(posedge clk) begin
            dp[0] <= (32'(oidx) << 16) ^ seed[g];
            for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
        end
        initial forever begin
            @(posedge clk);
            #1;
            rdy = (mode[g] == 0) ? 1'b1
                : (mode[g] == 1) ? 1'($urandom_range(0, 1))
                : 1'(((cyc / 4) % 2) == 0);
        end
        initial begin
            beat = 0;
            hold = 1'b0;
            prev = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    beat = 0;
                    hold = 1'b0;
                end else begin
                    if (hold) chk("hold", 64'({m_valid, m_last, mdata}), 64'({1'b1, prev}));
                    if (m_valid && rdy) begin
                        chk("beat", 64'({m_last, mdata}), 64'({beat == FL - 1, (32'(beat) << 16) ^ seed[g]}));
                        beat++;
                    end
                    if (frame_done) begin
                        chk("frame_beats", 64'(beat), 64'(FL));
                        beat = 0;
                    end
                    hold = m_valid && !rdy;
                    prev = {m_last, mdata};
                end
            end
        end
    end
    task automatic pulse_start(input int g, output int n);
        start_v[g] = 1'b1;
        n = cyc;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask
    task automatic wait_for(input int g, input bit done, input int n, input int lim, output int rel);
        rel = -1;
        for (int i = 0; i < lim; i++) begin
            if (done ? done_v[g] : val_v[g]) begin
                rel = cyc - n;
                break;
            end
            @(negedge clk);
        end
    endtask
    task automatic wait_beat(input int k);
        for (int i = 0; i < 20000 && gi[0].beat < k; i++) @(negedge clk);
        chk("reach_bin", 64'(gi[0].beat >= k), 64'(1));
    endtask
    initial begin
        int n, rel, stray;
        rst = 1'b1;
        start_v = '0;
        mode = '{0, 0};
        seed = '{32'd0, 32'd0};
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_v), 64'(0));
        chk("rst_valid", 64'(val_v), 64'(0));
        chk("rst_done", 64'(done_v), 64'(0));
        chk("rst_idx", 64'({gi[0].oidx, gi[1].oidx}), 64'(0));
        chk("rst_data0", 64'({gi[0].m_last, gi[0].mdata}), 64'(0));
        chk("rst_data1", 64'({gi[1].m_last, gi[1].mdata}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        pulse_start(0, n);
        chk("start_busy", 64'(busy_v[0]), 64'(1));
        chk("start_idx", 64'(gi[0].oidx), 64'(0));
        wait_for(0, 1'b0, n, 50, rel);
        chk("first_valid", 64'(rel), 64'(3));
        wait_for(0, 1'b1, n, 5000, rel);
        chk("done_cycle", 64'(rel), 64'(FL + 3));
        chk("busy_fall", 64'(busy_v[0]), 64'(0));
        chk("gap", 64'(val_v[0]), 64'(0));
        seed[0] = $urandom;
        mode[0] = 1;
        pulse_start(0, n);
        chk("b2b_busy", 64'(busy_v[0]), 64'(1));
        chk("b2b_idx", 64'(gi[0].oidx), 64'(0));
        wait_for(0, 1'b0, n, 50, rel);
        chk("b2b_first", 64'(rel), 64'(3));
        wait_for(0, 1'b1, n, 20000, rel);
        chk("b2b_done", 64'(rel > 0), 64'(1));
        seed[0] = $urandom;
        mode[0] = 0;
        @(negedge clk);
        pulse_start(0, n);
        wait_beat(100);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_for(0, 1'b1, n, 5000, rel);
        chk("restart_ignored", 64'(rel), 64'(FL + 3));
        rst = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start_busy", 64'(busy_v[0]), 64'(0));
        chk("rst_start_valid", 64'(val_v[0]), 64'(0));
        seed[0] = $urandom;
        pulse_start(0, n);
        wait_beat(1000);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy_v[0]), 64'(0));
        chk("abort_valid", 64'(val_v[0]), 64'(0));
        chk("abort_done", 64'(done_v[0]), 64'(0));
        chk("abort_idx", 64'(gi[0].oidx), 64'(0));
        chk("abort_data", 64'({gi[0].m_last, gi[0].mdata}), 64'(0));
        rst = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            stray += int'(val_v[0] | done_v[0]);
        end
        chk("stray", 64'(stray), 64'(0));
        seed[0] = $urandom;
        mode[0] = 1;
        pulse_start(0, n);
        wait_for(0, 1'b0, n, 50, rel);
        chk("refill_first", 64'(rel), 64'(3));
        wait_for(0, 1'b1, n, 20000, rel);
        chk("refill_done", 64'(rel > 0), 64'(1));
        seed[1] = $urandom;
        mode[1] = 2;
        @(negedge clk);
        pulse_start(1, n);
        chk("lat3_idx", 64'(gi[1].oidx), 64'(0));
        wait_for(1, 1'b0, n, 50, rel);
        chk("lat3_first", 64'(rel), 64'(5));
        wait_for(1, 1'b1, n, 20000, rel);
        chk("lat3_done", 64'(rel > 0), 64'(1));
        chk("lat3_busy_fall", 64'(busy_v[1]), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
